// File: rtl/wqe_seg_parser.sv
// WQE segment parser: splits the 128-bit segment stream into one header record
// per WQE followed by its ordered scatter/gather entries.
//
// state   | meaning
// CTRL_s  | waiting for / accepting the ctrl segment of a new WQE
// RADDR_s | accepting the remote-address segment
// HDR_s   | header record presented, waiting for hdr_ready
// DATA_s  | forwarding data segments through the one-entry SGE register
// DRAIN_s | last SGE loaded, waiting for it to be taken
module wqe_seg_parser #(
  parameter logic [31:0] RADDR_OP_MASK = 32'h0000_0118
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wqe_seg_valid,
  input  logic [127:0] wqe_seg_data,
  output logic         wqe_seg_ready,
  output logic         hdr_valid,
  input  logic         hdr_ready,
  output logic [4:0]   hdr_opcode,
  output logic [23:0]  hdr_qpn,
  output logic [31:0]  hdr_imm,
  output logic [63:0]  hdr_raddr,
  output logic [31:0]  hdr_rkey,
  output logic [5:0]   hdr_sge_num,
  output logic         hdr_err,
  output logic         sge_valid,
  input  logic         sge_ready,
  output logic [31:0]  sge_len,
  output logic [31:0]  sge_lkey,
  output logic [63:0]  sge_laddr,
  output logic         sge_last
);

  typedef enum logic [2:0] {
    CTRL_s  = 3'd0,
    RADDR_s = 3'd1,
    HDR_s   = 3'd2,
    DATA_s  = 3'd3,
    DRAIN_s = 3'd4
  } state_t;

  state_t     state;
  logic [5:0] sge_left;

  logic [4:0] seg_opcode;
  logic [5:0] seg_ds;
  logic       seg_has_raddr;
  logic [6:0] seg_need;
  logic [6:0] seg_diff;
  logic       seg_err;
  logic [5:0] seg_sge_num;
  logic       seg_accept;

  assign seg_opcode    = wqe_seg_data[4:0];
  assign seg_ds        = wqe_seg_data[13:8];
  assign seg_has_raddr = RADDR_OP_MASK[seg_opcode];
  assign seg_need      = 7'd1 + {6'd0, seg_has_raddr};
  assign seg_diff      = {1'b0, seg_ds} - seg_need;
  // size check is done in 7 bits so a too-small ds flags an error instead of wrapping
  assign seg_err       = ({1'b0, seg_ds} < seg_need);
  assign seg_sge_num   = seg_err ? 6'd0 : seg_diff[5:0];
  assign seg_accept    = wqe_seg_valid && wqe_seg_ready;

  always_comb begin
    wqe_seg_ready = 1'b0;
    if (!rst) begin
      case (state)
        CTRL_s, RADDR_s: wqe_seg_ready = 1'b1;
        DATA_s:          wqe_seg_ready = !sge_valid || sge_ready;
        default:         wqe_seg_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CTRL_s;
      sge_left    <= 6'd0;
      hdr_valid   <= 1'b0;
      hdr_opcode  <= 5'd0;
      hdr_qpn     <= 24'd0;
      hdr_imm     <= 32'd0;
      hdr_raddr   <= 64'd0;
      hdr_rkey    <= 32'd0;
      hdr_sge_num <= 6'd0;
      hdr_err     <= 1'b0;
      sge_valid   <= 1'b0;
      sge_len     <= 32'd0;
      sge_lkey    <= 32'd0;
      sge_laddr   <= 64'd0;
      sge_last    <= 1'b0;
    end else begin
      if (sge_valid && sge_ready) begin
        sge_valid <= 1'b0;
      end

      case (state)
        CTRL_s: begin
          if (seg_accept) begin
            hdr_opcode  <= seg_opcode;
            hdr_qpn     <= wqe_seg_data[55:32];
            hdr_imm     <= wqe_seg_data[95:64];
            hdr_raddr   <= 64'd0;
            hdr_rkey    <= 32'd0;
            hdr_sge_num <= seg_sge_num;
            hdr_err     <= seg_err;
            if (seg_err || !seg_has_raddr) begin
              hdr_valid <= 1'b1;
              state     <= HDR_s;
            end else begin
              state     <= RADDR_s;
            end
          end
        end

        RADDR_s: begin
          if (seg_accept) begin
            hdr_raddr <= wqe_seg_data[63:0];
            hdr_rkey  <= wqe_seg_data[95:64];
            hdr_valid <= 1'b1;
            state     <= HDR_s;
          end
        end

        HDR_s: begin
          if (hdr_ready) begin
            hdr_valid <= 1'b0;
            if (hdr_err || (hdr_sge_num == 6'd0)) begin
              state <= CTRL_s;
            end else begin
              sge_left <= hdr_sge_num;
              state    <= DATA_s;
            end
          end
        end

        DATA_s: begin
          if (seg_accept) begin
            sge_valid <= 1'b1;
            sge_len   <= wqe_seg_data[31:0];
            sge_lkey  <= wqe_seg_data[63:32];
            sge_laddr <= wqe_seg_data[127:64];
            sge_last  <= (sge_left == 6'd1);
            sge_left  <= sge_left - 6'd1;
            if (sge_left == 6'd1) begin
              state <= DRAIN_s;
            end
          end
        end

        DRAIN_s: begin
          // next WQE is held off until the final SGE has left the register
          if (!sge_valid || sge_ready) begin
            state <= CTRL_s;
          end
        end

        default: state <= CTRL_s;
      endcase
    end
  end

endmodule
